regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
- Writeback buffer directly upstream of the 8-entry register file.
- Accepts write requests from two producers, the ALU and the load unit, into a small in-order FIFO.
- Drains at most one entry per cycle onto the register file write port (destReg, writeData, regWrite).
- Exports a per-register pending scoreboard so issue logic can stall reads of registers with writes still in flight.

Parameters:
W_width, 32, data width; must match the register file.
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous active-high reset
flush  input  1  synchronous clear of all queued entries
alu_valid  input  1  ALU write request
alu_dest  input  3  ALU destination register
alu_data  input  W_width  ALU result
alu_ready  output  1  ALU request accepted this cycle when high with alu_valid
ld_valid  input  1  load-unit write request
ld_dest  input  3  load destination register
ld_data  input  W_width  load data
ld_ready  output  1  load request accepted this cycle when high with ld_valid
destReg  output  3  to register file destReg
writeData  output  W_width  to register file writeData
regWrite  output  1  to register file regWrite
pending  output  8  bit r high while any queued entry targets register r
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset: RST high at a rising edge clears all entries, count, and read/write pointers. Outputs after that edge: regWrite=0, destReg=0, writeData=0, pending=0, empty=1, full=0. With reset held, alu_ready=0 and ld_ready=0. Reset overrides flush and all enqueues.
- Storage: circular FIFO of {dest[2:0], data} with rd_ptr, wr_ptr (log2(DEPTH) bits, natural wrap) and count (0..DEPTH).
- Head drive:
  - destReg, writeData and regWrite come combinationally from the head entry.
  - regWrite = !empty.
  - When empty, destReg=0 and writeData=0.
- Pop: whenever !empty, the head is popped at every rising edge, because the register file always accepts. rd_ptr advances by 1 and count decrements.
- Free slots for this cycle: free = DEPTH - count + (empty ? 0 : 1). Credit is given for the same-cycle pop.
- Ready rules:
  - ld_ready = (free >= 1).
  - alu_ready = (free >= 2) or (free >= 1 and !ld_valid).
  - The load unit has priority.
  - Both readies are 0 while flush=1 or RST=1.
- Enqueue ordering: if both producers are accepted in the same cycle, the load entry is written at wr_ptr and the ALU entry at wr_ptr+1. wr_ptr advances by the number accepted (0, 1 or 2).
- Count update: count_next = count + accepted - popped.
- Latency: a request accepted at edge N drives regWrite during cycle N→N+1 if the queue was empty or just drained, and is written into the register file at edge N+1. Queued entries are serviced strictly FIFO; total order is load-before-ALU within a cycle, arrival order across cycles.
- Same destination twice: both entries are kept, in order. The later entry wins in the register file. pending[r] stays high until the last entry targeting r pops.
- pending: combinational OR over all valid entries of one-hot(dest). An entry popped at edge N no longer contributes after edge N. An entry enqueued at edge N contributes from edge N onward.
- Flush:
  - At the edge: count, rd_ptr and wr_ptr go to 0; same-cycle requests are dropped (their readies were 0).
  - During the flush cycle the head entry is still presented with regWrite=1. The register file commits that write at the flush edge.
- Overflow: never occurs, because the ready logic prevents it. Assertion: count <= DEPTH always.
- Underflow: never occurs, because pop is gated by !empty.

Test Plan:
- Reset: hold RST 2 cycles with alu_valid=1 -> regWrite=0, pending=0x00, empty=1, alu_ready=0. Release -> alu_ready=1.
- Single write: ALU dest=3, data=0xDEADBEEF for one cycle, queue empty -> next cycle regWrite=1, destReg=3, writeData=0xDEADBEEF, pending=0x08. The following cycle regWrite=0, pending=0x00.
- Dual enqueue: ld dest=5 data=0x11 and alu dest=2 data=0x22 in the same cycle -> both accepted. Register file writes R5=0x11, then R2=0x22 on consecutive edges. pending goes 0x24 -> 0x04 -> 0x00.
- Full/backpressure: DEPTH=4, hold ld_valid and alu_valid high every cycle with incrementing data -> steady state is one pop per cycle, alu_ready=0 whenever free<2. No entry is lost or reordered; check against a scoreboard model.
- Same destination: alu dest=1 data=0xA, then next cycle alu dest=1 data=0xB -> two regWrite pulses in order. pending[1] stays high until the 0xB entry pops. Final R1=0xB.
- Flush: 3 entries queued, assert flush one cycle with ld_valid=1 -> head write commits at the flush edge, remaining entries are discarded, the load is not accepted, and after the edge empty=1 and pending=0x00.

Source files
------------

// File: rtl/regfile_wb_queue_if.sv
// Producer request channels and register-file write port of the writeback queue.
// master: the side that issues requests and observes the write port.
// slave:  the queue itself.
interface regfile_wb_queue_if #(
   parameter int W_width = 32
);
   logic               alu_valid;
   logic [2:0]         alu_dest;
   logic [W_width-1:0] alu_data;
   logic               alu_ready;

   logic               ld_valid;
   logic [2:0]         ld_dest;
   logic [W_width-1:0] ld_data;
   logic               ld_ready;

   logic [2:0]         destReg;
   logic [W_width-1:0] writeData;
   logic               regWrite;

   modport master (
      output alu_valid, alu_dest, alu_data,
      input  alu_ready,
      output ld_valid, ld_dest, ld_data,
      input  ld_ready,
      input  destReg, writeData, regWrite
   );

   modport slave (
      input  alu_valid, alu_dest, alu_data,
      output alu_ready,
      input  ld_valid, ld_dest, ld_data,
      output ld_ready,
      output destReg, writeData, regWrite
   );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 8-entry register file. The ALU and the load
// unit enqueue into an in-order circular FIFO; the head drains one entry per
// cycle onto the register-file write port. A per-register pending vector lets
// issue logic stall reads of registers that still have writes in flight.
module regfile_wb_queue #(
   parameter int W_width = 32,
   parameter int DEPTH   = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            flush,
   regfile_wb_queue_if.slave q,
   output logic [7:0]      pending,
   output logic            full,
   output logic            empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [2:0]         dest_q [DEPTH];
   logic [W_width-1:0] data_q [DEPTH];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      alu_slot;
   logic [PW:0]        count;
   logic [PW:0]        free;
   logic               pop;
   logic               ld_acc;
   logic               alu_acc;
   logic               open;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);
   assign pop   = !empty;

   // The head always drains this cycle, so its slot counts as free already.
   assign free  = DEPTH_C - count + {{PW{1'b0}}, pop};
   assign open  = !RST && !flush;

   // Load unit has priority; the ALU needs a second slot if the load also wants one.
   assign q.ld_ready  = open && (free >= (PW+1)'(1));
   assign q.alu_ready = open && ((free >= (PW+1)'(2)) ||
                                 ((free >= (PW+1)'(1)) && !q.ld_valid));

   assign ld_acc   = q.ld_valid  && q.ld_ready;
   assign alu_acc  = q.alu_valid && q.alu_ready;
   assign alu_slot = wr_ptr + PW'(ld_acc);

   // Head entry drives the register-file write port directly.
   assign q.regWrite  = pop;
   assign q.destReg   = pop ? dest_q[rd_ptr] : 3'd0;
   assign q.writeData = pop ? data_q[rd_ptr] : '0;

   // Pending scoreboard: one-hot OR of the destinations of all live entries.
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, PW'(i) - rd_ptr} < count) begin
            pending[dest_q[i]] = 1'b1;
         end
      end
   end

   // Pointer, count and entry storage update; reset beats flush beats enqueue.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= 3'd0;
            data_q[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (ld_acc) begin
            dest_q[wr_ptr] <= q.ld_dest;
            data_q[wr_ptr] <= q.ld_data;
         end
         if (alu_acc) begin
            dest_q[alu_slot] <= q.alu_dest;
            data_q[alu_slot] <= q.alu_data;
         end
         rd_ptr <= rd_ptr + PW'(pop);
         wr_ptr <= wr_ptr + PW'(ld_acc) + PW'(alu_acc);
         count  <= count + (PW+1)'(ld_acc) + (PW+1)'(alu_acc) - (PW+1)'(pop);
      end
   end

   // The ready logic must keep occupancy within the FIFO depth.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (count <= DEPTH_C);
      end
   end
endmodule
